// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit for the MIPS datapath. Executes MULTU, MULT,
//   DIVU and DIV over WIDTH iterations into private HI/LO registers, and
//   supports MTHI/MTLO writes while idle.
//
//   Ports
//     clk_i      : clock, rising edge
//     rst_n_i    : asynchronous active-low reset
//     start_i    : launch an operation (sampled only while idle)
//     op_i       : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//     rs_data_i  : multiplicand / dividend
//     rt_data_i  : multiplier / divisor
//     hi_we_i    : MTHI write strobe (idle only)
//     lo_we_i    : MTLO write strobe (idle only)
//     wdata_i    : MTHI/MTLO data
//     busy_o     : operation in flight, used as pipeline stall request
//     done_o     : one-cycle pulse after HI/LO are updated by an operation
//     hi_o/lo_o  : HI and LO registers
//
//   Timing: start sampled at edge N, WIDTH iterations on edges N+1..N+WIDTH,
//   sign fix and HI/LO write on edge N+WIDTH+1.
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] rs_data_i,
   input  logic [WIDTH-1:0] rt_data_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   opnd;      // multiplicand for MUL, divisor for DIV
   logic [2*WIDTH-1:0] acc;       // {upper, lower}: product or {remainder, quotient}
   logic               is_div;
   logic               neg_main;  // negate product / quotient
   logic               neg_rem;   // negate remainder
   logic               div_zero;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               busy_reg;
   logic               done_reg;

   // Operand magnitudes at launch; the most-negative value maps onto itself,
   // which is exactly its unsigned magnitude.
   logic             rs_neg;
   logic             rt_neg;
   logic [WIDTH-1:0] rs_mag;
   logic [WIDTH-1:0] rt_mag;

   always_comb begin
      rs_neg = op_i[0] & rs_data_i[WIDTH-1];
      rt_neg = op_i[0] & rt_data_i[WIDTH-1];
      rs_mag = rs_neg ? (~rs_data_i + WIDTH'(1)) : rs_data_i;
      rt_mag = rt_neg ? (~rt_data_i + WIDTH'(1)) : rt_data_i;
   end

   // One iteration of shift-add multiply and restoring divide.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_sh;
   logic               div_ge;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      // Add the multiplicand into the upper half when the current multiplier
      // bit is set, then shift the whole product right (carry drops into MSB).
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc[WIDTH-1:1]};

      // Remainder shifted left with the next dividend bit brought in. It is
      // below 2*divisor, so the W-bit difference is exact whenever it is kept.
      rem_sh   = acc[2*WIDTH-1:WIDTH-1];
      div_ge   = (rem_sh >= {1'b0, opnd});
      div_diff = rem_sh[WIDTH-1:0] - opnd;
      div_next = {(div_ge ? div_diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
   end

   // Sign correction applied in FIX.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   always_comb begin
      prod_fix = neg_main ? (~acc + (2*WIDTH)'(1)) : acc;
      quo_fix  = neg_main ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
      rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc[2*WIDTH-1:WIDTH];
      // Divide by zero: the remainder path already reproduces rs; force LO.
      if (div_zero) begin
         quo_fix = {WIDTH{1'b1}};
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= IDLE;
         count    <= '0;
         opnd     <= '0;
         acc      <= '0;
         is_div   <= 1'b0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         hi_reg   <= '0;
         lo_reg   <= '0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state)
            IDLE: begin
               // MTHI/MTLO land here; a simultaneous start overwrites them in FIX.
               if (hi_we_i) hi_reg <= wdata_i;
               if (lo_we_i) lo_reg <= wdata_i;
               if (start_i) begin
                  is_div   <= op_i[1];
                  neg_main <= rs_neg ^ rt_neg;
                  neg_rem  <= rs_neg;
                  div_zero <= op_i[1] & (rt_data_i == '0);
                  opnd     <= op_i[1] ? rt_mag : rs_mag;
                  acc      <= {{WIDTH{1'b0}}, (op_i[1] ? rs_mag : rt_mag)};
                  count    <= '0;
                  busy_reg <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               acc <= is_div ? div_next : mul_next;
               if (count == LAST_ITER) begin
                  state <= FIX;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            FIX: begin
               if (is_div) begin
                  hi_reg <= rem_fix;
                  lo_reg <= quo_fix;
               end else begin
                  hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_reg <= prod_fix[WIDTH-1:0];
               end
               done_reg <= 1'b1;
               busy_reg <= 1'b0;
               count    <= '0;
               state    <= IDLE;
            end
            default: begin
               busy_reg <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign busy_o = busy_reg;
   assign done_o = done_reg;
   assign hi_o   = hi_reg;
   assign lo_o   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit: stimulus pushes hand-computed HI/LO
//   results, a monitor pops and compares on every done_o pulse and checks the
//   busy window length.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] rs_data;
   logic [W-1:0] rt_data;
   logic         hi_we;
   logic         lo_we;
   logic [W-1:0] wdata;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   busy_run = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .start_i   (start),
      .op_i      (op),
      .rs_data_i (rs_data),
      .rt_data_i (rt_data),
      .hi_we_i   (hi_we),
      .lo_we_i   (lo_we),
      .wdata_i   (wdata),
      .busy_o    (busy),
      .done_o    (done),
      .hi_o      (hi),
      .lo_o      (lo)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: outputs are sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_run = 0;
      end else begin
         if (busy) busy_run++;
         if (done) begin
            chk("busy_len", W'(busy_run), W'(33));
            busy_run = 0;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=hi:%h,lo:%h expected=no_result", hi, lo);
            end else begin
               e = sb.pop_front();
               $display("txn done hi=%h lo=%h (exp hi=%h lo=%h)", hi, lo, e.hi, e.lo);
               chk("result_hi", hi, e.hi);
               chk("result_lo", lo, e.lo);
            end
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo);
      exp_t e;
      @(negedge clk);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      e.hi    = ehi;
      e.lo    = elo;
      sb.push_back(e);
      @(negedge clk);
      start   = 1'b0;
      // Scramble operands: they must have been latched at start.
      rs_data = $urandom;
      rt_data = $urandom;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 60) begin
         failures++;
         $display("FAIL wait_done actual=timeout expected=completion_within_60");
      end
      @(negedge clk);
   endtask

   task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ehi, input logic [W-1:0] elo);
      issue(o, a, b, ehi, elo);
      wait_done();
   endtask

   task automatic mt(input bit to_hi, input logic [W-1:0] d);
      @(negedge clk);
      hi_we = to_hi;
      lo_we = !to_hi;
      wdata = d;
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      op      = 2'b00;
      rs_data = '0;
      rt_data = '0;
      hi_we   = 1'b0;
      lo_we   = 1'b0;
      wdata   = '0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_hi", hi, '0);
      chk("reset_lo", lo, '0);
      chk("reset_busy", W'(busy), '0);
      chk("reset_done", W'(done), '0);

      // Directed operations: op, rs, rt, expected HI, expected LO
      run(2'b00, 32'd7,        32'd6,        32'h0000_0000, 32'h0000_002A);
      run(2'b01, 32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run(2'b11, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run(2'b10, 32'h0000_1234, 32'd0,       32'h0000_1234, 32'hFFFF_FFFF);
      run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run(2'b11, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      run(2'b11, 32'hFFFF_FFF9, 32'd0,       32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run(2'b10, 32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E);

      // MTHI together with start: write occurs, result overwrites it later.
      begin
         exp_t e;
         @(negedge clk);
         start = 1'b1; op = 2'b00; rs_data = 32'd7; rt_data = 32'd6;
         hi_we = 1'b1; wdata = 32'h0000_BEEF;
         e.hi = 32'h0; e.lo = 32'h2A;
         sb.push_back(e);
         @(negedge clk);
         start = 1'b0; hi_we = 1'b0;
         chk("mthi_with_start", hi, 32'h0000_BEEF);
         wait_done();
      end

      // Start and MTHI while busy are ignored.
      mt(1'b1, 32'h0000_0011);
      issue(2'b00, 32'd3, 32'd3, 32'h0, 32'h9);
      repeat (8) @(negedge clk);
      start = 1'b1; op = 2'b10; rs_data = 32'd9; rt_data = 32'd0;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_ignored_start", W'(busy), W'(1));
      @(negedge clk);
      hi_we = 1'b1; wdata = 32'h0000_00AA;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi_ignored_busy", hi, 32'h0000_0011);
      chk("busy_mid_op", W'(busy), W'(1));
      wait_done();

      // Asynchronous reset mid-operation.
      mt(1'b1, 32'h0000_0077);
      @(negedge clk);
      start = 1'b1; op = 2'b11; rs_data = 32'hFFFF_FFF9; rt_data = 32'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (13) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_hi", hi, '0);
      chk("async_rst_lo", lo, '0);
      chk("async_rst_busy", W'(busy), '0);
      chk("async_rst_done", W'(done), '0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      mt(1'b0, 32'h0000_0055);
      chk("mtlo_after_rst", lo, 32'h0000_0055);
      chk("hi_after_mtlo", hi, '0);
      repeat (40) @(negedge clk);
      chk("idle_after_rst_busy", W'(busy), '0);
      chk("lo_holds", lo, 32'h0000_0055);
      chk("sb_empty", W'(sb.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
